// File: rtl/gray_conv_seq.sv
// Handshaked binary<->Gray converter: binary->Gray in one cycle, Gray->binary
// resolved STEP bits per cycle MSB first, with a count of handed-off results.
module gray_conv_seq #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             gray_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Dout,
    output logic [CNT_W-1:0] conv_cnt
);

    localparam int GROUPS = WIDTH / STEP;
    localparam int K_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_g;
    logic [WIDTH-1:0]   r_b;
    logic [K_W-1:0]     r_k;
    logic [WIDTH-1:0]   r_dout;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic               w_accept;
    logic               w_last;

    assign in_ready  = (r_state == IDLE) && EN && !rst;
    assign out_valid = (r_state == HOLD);
    assign Dout      = r_dout;
    assign conv_cnt  = r_cnt;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_k == K_W'(GROUPS - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = gray_n ? CONV : HOLD;
            CONV:    if (w_last)    w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Bits above group k are already final in r_b; group k chains off them.
    always_comb begin : resolve
        logic v_hi;
        w_b_nxt = r_b;
        v_hi    = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (((WIDTH - 1 - i) / STEP) == int'(r_k))
                w_b_nxt[i] = v_hi ^ r_g[i];
            v_hi = w_b_nxt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g    <= '0;
            r_b    <= '0;
            r_k    <= '0;
            r_dout <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (gray_n) begin
                            r_g <= Din;
                            r_b <= '0;
                            r_k <= '0;
                        end else begin
                            r_dout <= Din ^ (Din >> 1);
                        end
                    end
                end
                CONV: begin
                    r_b <= w_b_nxt;
                    r_k <= r_k + 1'b1;
                    if (w_last) r_dout <= w_b_nxt;
                end
                HOLD: begin
                    if (out_ready) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/gray_conv_seq.md
Name: gray_conv_seq

Overview:
Parametrised, handshaked, bidirectional binary/Gray code converter and the registered successor to the 4-bit combinational encoder.
- Binary-to-Gray completes in one cycle.
- Gray-to-binary is resolved iteratively, STEP bits per cycle, MSB first. This trades latency for a short XOR chain on wide words.
- Sits between a valid/ready producer and consumer.
- Keeps a count of completed conversions for status readout.

Parameters:
WIDTH, 8, data word width in bits; WIDTH >= 2.
STEP, 1, Gray-to-binary bits resolved per cycle; WIDTH must be divisible by STEP.
CNT_W, 16, width of the completed-conversion counter.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  reset; asynchronous, active-high.
EN  input  1  acceptance enable; EN=0 blocks new transactions only.
gray_n  input  1  mode, sampled at acceptance: 0 = binary->Gray, 1 = Gray->binary.
in_valid  input  1  Din/gray_n valid.
in_ready  output  1  block can accept; equals (state==IDLE) && EN.
Din  input  WIDTH  input word.
out_valid  output  1  Dout holds a completed result.
out_ready  input  1  consumer accepts Dout.
Dout  output  WIDTH  converted word; registered.
conv_cnt  output  CNT_W  number of results handed off since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE.
  - out_valid=0, Dout=0, conv_cnt=0.
  - Internal capture, partial-result and group counter registers are cleared.
  - in_ready=0 while rst=1.
  - A transaction in flight is aborted; no output is produced for it.
- States: IDLE, CONV, HOLD.
- IDLE:
  - Acceptance occurs on a rising edge with in_valid && in_ready.
  - Din and gray_n are captured on that edge. Later changes to Din or gray_n have no effect on the transaction.
  - gray_n=0: Dout <= Din ^ (Din >> 1) and out_valid <= 1 on the acceptance edge; go to HOLD. Latency is 1 cycle.
  - gray_n=1: capture g=Din, clear k; go to CONV.
- CONV:
  - On each edge, resolve group k (bits WIDTH-1-k*STEP down to WIDTH-(k+1)*STEP).
  - For the top bit, b[WIDTH-1]=g[WIDTH-1]; for lower bits, b[i]=b[i+1]^g[i].
  - k increments each edge.
  - On the edge resolving the last group (k == WIDTH/STEP-1): Dout <= b, out_valid <= 1; go to HOLD.
  - Latency from the acceptance edge to out_valid high is WIDTH/STEP+1 cycles. For defaults: 9 cycles.
- HOLD:
  - out_valid=1; Dout is stable while out_ready=0, with unbounded backpressure.
  - On an edge with out_valid && out_ready: out_valid <= 0, conv_cnt <= conv_cnt+1, state <= IDLE.
- in_ready is 0 in CONV and HOLD; there is no overlap between transactions.
  - Maximum throughput is one binary->Gray transaction per 2 cycles.
  - A new acceptance may occur on the cycle after the handoff edge.
- EN:
  - EN=0 deasserts in_ready combinationally.
  - Deasserting EN in CONV or HOLD does not abort the transaction; it completes and hands off normally.
- Dout retains the last result after handoff until the next result loads; it is not cleared.
- conv_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Gray->binary followed by binary->Gray of the same word is identity for every WIDTH-bit value.

Test Plan:
- Reset: hold rst=1 with in_valid=1, EN=1 -> in_ready=0, out_valid=0, Dout=0x00, conv_cnt=0. Assert rst mid-CONV -> out_valid=0 and Dout=0x00 immediately, with no result afterwards.
- Binary->Gray (WIDTH=8): EN=1, gray_n=0, Din=0x5A accepted -> out_valid=1 the next cycle, Dout=0x77. With out_ready=1, out_valid drops on the following edge and conv_cnt=1.
- Gray->binary (WIDTH=8, STEP=1): gray_n=1, Din=0x77 -> out_valid rises 9 cycles after acceptance, Dout=0x5A. Sweep all 256 codes through both modes and check round-trip identity.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> Dout stable, in_ready=0, conv_cnt unchanged. Then out_ready=1 -> single increment of conv_cnt, and IDLE on the next cycle.
- EN gating:
  - EN=0 with in_valid=1 for 10 cycles -> no acceptance, out_valid stays 0.
  - EN dropped 2 cycles into CONV -> the result still completes.
  - Changing Din during CONV does not alter the result.
- STEP=4, WIDTH=8: gray_n=1, Din=0x80 -> out_valid 3 cycles after acceptance, Dout=0xFF. Drive 2^CNT_W handoffs with CNT_W=4 -> conv_cnt wraps to 0.
